// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus between fetch and memory
interface fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch with credit-limited requests, in-order buffer, redirect flush; FETCH_MISALIGN_TRAP_EN adds fetch_fault
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [31:0]   dec_insn,
  output logic [31:0]   dec_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic          fetch_fault
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(BUF_DEPTH);

  logic [31:0]   pc;
  logic          started;
  logic          halted;
  logic [CW-1:0] inflight, drop, occ, inflight_nxt;
  logic [CW:0]   used;
  logic          acc, keep, pop;
  logic [31:0]   rq_pc [BUF_DEPTH];
  logic [AW-1:0] rq_wr, rq_rd;
  logic [31:0]   fq_pc [BUF_DEPTH];
  logic [31:0]   fq_insn [BUF_DEPTH];
  logic [AW-1:0] fq_wr, fq_rd;

  assign used = {1'b0, inflight} + {1'b0, occ};
  assign imem.req_valid = started && !halted && used < DEPTH;
  assign imem.req_addr = pc;
  assign acc = imem.req_valid && imem.req_ready;
  assign keep = imem.rsp_valid && drop == '0 && !redirect_valid;
  assign dec_valid = occ != '0 && !redirect_valid;
  assign pop = dec_valid && dec_ready;
  assign dec_insn = fq_insn[fq_rd];
  assign dec_pc = fq_pc[fq_rd];
  assign inflight_nxt = inflight + CW'(acc) - CW'(imem.rsp_valid);

  // program counter: redirect wins, otherwise advance on each accepted request
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) pc <= redirect_pc & ~32'h3;
      else if (acc) pc <= pc + 32'd4;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
  // misaligned redirect traps and halts fetch until an aligned redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) halted <= 1'b0;
    else if (redirect_valid) halted <= redirect_pc[1:0] != 2'b00;
  assign fetch_fault = halted;
`else
  assign halted = 1'b0;
`endif

  // outstanding requests and stale responses still to be discarded
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight <= '0;
      drop <= '0;
    end else begin
      inflight <= inflight_nxt;
      drop <= redirect_valid ? inflight_nxt : drop - CW'(imem.rsp_valid && drop != '0);
    end

  // request-PC queue pointers: every response, dropped or kept, retires one entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rq_wr <= '0;
      rq_rd <= '0;
    end else begin
      if (acc) rq_wr <= rq_wr + 1'b1;
      if (imem.rsp_valid) rq_rd <= rq_rd + 1'b1;
    end

  // request-PC storage pairs each response with its fetch address
  always_ff @(posedge clk)
    if (acc) rq_pc[rq_wr] <= pc;

  // instruction buffer toward decode, emptied on redirect
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fq_wr <= '0;
      fq_rd <= '0;
      occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fq_pc[i] <= '0;
        fq_insn[i] <= '0;
      end
    end else if (redirect_valid) begin
      fq_wr <= '0;
      fq_rd <= '0;
      occ <= '0;
    end else begin
      if (keep) begin
        fq_pc[fq_wr] <= rq_pc[rq_rd];
        fq_insn[fq_wr] <= imem.rsp_data;
        fq_wr <= fq_wr + 1'b1;
      end
      if (pop) fq_rd <= fq_rd + 1'b1;
      occ <= occ + CW'(keep) - CW'(pop);
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage with a latency-programmable memory model
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic dec_valid;
  logic dec_ready = 1'b1;
  logic [31:0] dec_insn, dec_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_fault;
`endif
  int errs = 0;
  int checks = 0;
  int lat = 1;
  int cyc = 0;
  int n0;
  logic [31:0] pq_addr[$];
  int pq_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] dpc_log[$];
  logic [31:0] dins_log[$];

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(32'h100), .BUF_DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem(imem),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_insn(dec_insn),
    .dec_pc(dec_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs;
    acc_log.delete();
    dpc_log.delete();
    dins_log.delete();
  endtask

  initial begin
    imem.req_ready = 1'b1;
    imem.rsp_valid = 1'b0;
    imem.rsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
        imem.rsp_valid = 1'b1;
        imem.rsp_data = word(pq_addr[0]);
      end else begin
        imem.rsp_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (imem.rsp_valid) begin
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    if (imem.req_valid && imem.req_ready) begin
      pq_addr.push_back(imem.req_addr);
      pq_due.push_back(cyc + lat);
      acc_log.push_back(imem.req_addr);
    end
    if (dec_valid && dec_ready) begin
      dpc_log.push_back(dec_pc);
      dins_log.push_back(dec_insn);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", imem.req_valid, 0);
    chk("rst_req_addr", imem.req_addr, 32'h100);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_insn", dec_insn, 0);
    chk("rst_dec_pc", dec_pc, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_fault", fetch_fault, 0);
`endif
    rst_n = 1'b1;
    #1;
    chk("pre_edge_valid", imem.req_valid, 0);
    step;
    chk("first_req_valid", imem.req_valid, 1);
    chk("first_req_addr", imem.req_addr, 32'h100);
    step;
    chk("dec_valid_n1", dec_valid, 0);
    step;
    chk("dec_valid_n2", dec_valid, 1);
    chk("dec_pc_first", dec_pc, 32'h100);
    chk("dec_insn_first", dec_insn, 32'hDEAD_0100);
    repeat (8) step;

    dec_ready = 1'b0;
    n0 = acc_log.size();
    repeat (10) step;
    chk("bp_accepts_le2", acc_log.size() - n0 <= 2, 1);
    chk("bp_req_valid", imem.req_valid, 0);
    chk("bp_dec_valid", dec_valid, 1);
    dec_ready = 1'b1;
    repeat (15) step;
    chk("stream_cnt", dpc_log.size() >= 10, 1);
    chk("stream_acc_cnt", acc_log.size() >= dpc_log.size(), 1);
    foreach (dpc_log[i]) begin
      chk("stream_pc", dpc_log[i], 32'h100 + 32'(4 * i));
      chk("stream_insn", dins_log[i], word(32'h100 + 32'(4 * i)));
    end
    foreach (acc_log[i]) chk("stream_addr", acc_log[i], 32'h100 + 32'(4 * i));

    for (int i = 0; i < 20; i++) begin
      if (imem.rsp_valid && dec_valid) break;
      step;
    end
    chk("sim_found", imem.rsp_valid && dec_valid, 1);
    redirect_pc = 32'hFFFF_FFFC;
    redirect_valid = 1'b1;
    #1;
    chk("sim_dec_gated", dec_valid, 0);
    step;
    redirect_valid = 1'b0;
    clear_logs();
    chk("sim_fifo_empty", dec_valid, 0);
    chk("wrap_addr0", imem.req_addr, 32'hFFFF_FFFC);
    repeat (12) step;
    chk("wrap_cnt", acc_log.size() >= 2 && dpc_log.size() >= 2, 1);
    chk("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
    chk("wrap_acc1", acc_log[1], 32'h0000_0000);
    chk("wrap_dpc0", dpc_log[0], 32'hFFFF_FFFC);
    chk("wrap_dins0", dins_log[0], 32'h2152_FFFC);
    chk("wrap_dpc1", dpc_log[1], 32'h0000_0000);

    lat = 3;
    for (int i = 0; i < 40; i++) begin
      if (pq_addr.size() == 2 && !imem.rsp_valid) break;
      step;
    end
    chk("inf_two_pending", pq_addr.size() == 2 && !imem.rsp_valid, 1);
    redirect_pc = 32'h200;
    redirect_valid = 1'b1;
    step;
    redirect_valid = 1'b0;
    clear_logs();
    repeat (20) step;
    chk("inf_cnt", dpc_log.size() >= 2 && acc_log.size() >= 1, 1);
    chk("inf_acc0", acc_log[0], 32'h200);
    chk("inf_dpc0", dpc_log[0], 32'h200);
    chk("inf_dins0", dins_log[0], 32'hDEAD_0200);
    chk("inf_dpc1", dpc_log[1], 32'h204);

    redirect_pc = 32'h202;
    redirect_valid = 1'b1;
    step;
    redirect_valid = 1'b0;
    clear_logs();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault_set", fetch_fault, 1);
    repeat (5) step;
    chk("mis_no_req", acc_log.size(), 0);
    chk("mis_req_valid", imem.req_valid, 0);
    chk("mis_fault_hold", fetch_fault, 1);
    redirect_pc = 32'h300;
    redirect_valid = 1'b1;
    step;
    redirect_valid = 1'b0;
    clear_logs();
    chk("mis_fault_clr", fetch_fault, 0);
    repeat (15) step;
    chk("mis_cnt", dpc_log.size() >= 1 && acc_log.size() >= 1, 1);
    chk("mis_acc0", acc_log[0], 32'h300);
    chk("mis_dpc0", dpc_log[0], 32'h300);
    chk("mis_dins0", dins_log[0], 32'hDEAD_0300);
`else
    repeat (15) step;
    chk("mis_cnt", dpc_log.size() >= 1 && acc_log.size() >= 1, 1);
    chk("mis_acc0", acc_log[0], 32'h200);
    chk("mis_dpc0", dpc_log[0], 32'h200);
    chk("mis_dins0", dins_log[0], 32'hDEAD_0200);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
